// File: rtl/digit_serial_adder_ctrl.sv
// rtl/digit_serial_adder_ctrl.sv - 2-bit-per-cycle serial adder with start/busy/done control
// Optional subtract mode when DSA_SUB_EN is defined (adds the sub port).
module digit_serial_adder_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH/2) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef DSA_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_width_check
    $error("digit_serial_adder_ctrl: WIDTH must be even and >= 2");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH/2 - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_nxt;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic [1:0]       dsum;
  logic             c1, c2;
  logic             accept, last;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

`ifdef DSA_SUB_EN
  // Two's-complement subtract: invert B and force the initial carry.
  assign b_load = sub ? ~b : b;
  assign c_load = sub ? 1'b1 : cin;
`else
  assign b_load = b;
  assign c_load = cin;
`endif

  // The 2-bit ripple slice: two chained full adders.
  assign dsum[0] = a_sr[0] ^ b_sr[0] ^ carry;
  assign c1      = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
  assign dsum[1] = a_sr[1] ^ b_sr[1] ^ c1;
  assign c2      = (a_sr[1] & b_sr[1]) | (c1 & (a_sr[1] ^ b_sr[1]));

  if (WIDTH == 2) begin : g_res_w2
    assign res_nxt = dsum;
  end else begin : g_res_wn
    assign res_nxt = {dsum, res_sr[WIDTH-1:2]};
  end

  assign accept = start && (state == IDLE || state == DONE);
  assign last   = (state == RUN) && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else if (accept) begin
      a_sr  <= a;
      b_sr  <= b_load;
      carry <= c_load;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sr   <= a_sr >> 2;
      b_sr   <= b_sr >> 2;
      carry  <= c2;
      cnt    <= cnt + CNT_W'(1);
      res_sr <= res_nxt;
      // Outputs only change on the final digit so they hold the previous result during RUN.
      if (last) begin
        sum  <= res_nxt;
        cout <= c2;
      end
    end
  end

endmodule

// File: tb/tb_digit_serial_adder_ctrl.sv
// tb/tb_digit_serial_adder_ctrl.sv - directed table-driven bench for digit_serial_adder_ctrl
module tb_digit_serial_adder_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             cin;
  logic             sub;
  logic             busy, done, cout;
  logic [WIDTH-1:0] sum;

  int n_cmp = 0;
  int n_err = 0;
  logic [WIDTH-1:0] prev_sum;
  logic             prev_cout;

  always #5 clk = ~clk;

  digit_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef DSA_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  typedef struct {
    logic [WIDTH-1:0] va;
    logic [WIDTH-1:0] vb;
    logic             vcin;
    logic             vsub;
    logic [WIDTH-1:0] esum;
    logic             ecout;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Accept one operation, check busy/done timing and that outputs hold the old result during RUN.
  task automatic run_op(input string name, input vec_t v);
    logic [4:0] bz, dn;
    @(negedge clk);
    a = v.va; b = v.vb; cin = v.vcin; sub = v.vsub; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = ~v.va; b = ~v.vb; cin = ~v.vcin;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      bz[k-1] = busy;
      dn[k-1] = done;
      if (k == 2) check({name, " held sum"}, {23'd0, prev_cout, prev_sum}, {23'd0, cout, sum} ^ 32'd0);
    end
    check({name, " busy"}, {27'd0, bz}, 32'b01111);
    check({name, " done"}, {27'd0, dn}, 32'b10000);
    check({name, " sum"},  {24'd0, sum}, {24'd0, v.esum});
    check({name, " cout"}, {31'd0, cout}, {31'd0, v.ecout});
    prev_sum  = v.esum;
    prev_cout = v.ecout;
  endtask

  initial begin
    int ndone;
    logic [WIDTH-1:0] cap_sum;

    vecs.push_back('{8'h3C, 8'h45, 1'b0, 1'b0, 8'h81, 1'b0});
    vecs.push_back('{8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1});
    vecs.push_back('{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0});
    vecs.push_back('{8'hA5, 8'h5A, 1'b0, 1'b0, 8'hFF, 1'b0});
    vecs.push_back('{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0});
    vecs.push_back('{8'h96, 8'hC3, 1'b1, 1'b0, 8'h5A, 1'b1});
`ifdef DSA_SUB_EN
    vecs.push_back('{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0});
    vecs.push_back('{8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1});
    vecs.push_back('{8'h07, 8'h05, 1'b0, 1'b0, 8'h0C, 1'b0});
`endif

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    prev_sum = '0; prev_cout = 1'b0;

    // Reset then idle
    repeat (3) @(negedge clk);
    check("reset busy/done/sum/cout", {22'd0, busy, done, sum, cout}, 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("idle%0d outputs", k), {22'd0, busy, done, sum, cout}, 32'd0);
    end

    foreach (vecs[i]) run_op($sformatf("vec%0d", i), vecs[i]);

    // Start pulses during RUN are ignored
    @(negedge clk);
    a = 8'h3C; b = 8'h45; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    ndone = 0; cap_sum = '0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (done) begin ndone++; cap_sum = sum; end
      if (k == 2 || k == 3) begin start = 1'b1; a = 8'hFF; b = 8'hFF; end
      else start = 1'b0;
    end
    check("busy-start done count", ndone, 1);
    check("busy-start sum", {24'd0, cap_sum}, 32'h81);

    // Back-to-back accept in the DONE cycle
    @(negedge clk);
    a = 8'h3C; b = 8'h45; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("b2b first done", {31'd0, done}, 1);
    a = 8'h10; b = 8'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b no gap busy", {31'd0, busy}, 1);
    repeat (3) @(negedge clk);
    check("b2b still busy", {30'd0, busy, done}, 32'b10);
    @(negedge clk);
    check("b2b second done", {31'd0, done}, 1);
    check("b2b second sum", {23'd0, cout, sum}, 32'h011);

    // Reset mid-operation
    @(negedge clk);
    a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst outputs", {22'd0, busy, done, sum, cout}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    check("midrst no activity", ndone, 0);
    prev_sum = '0; prev_cout = 1'b0;
    run_op("post-reset", '{8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/digit_serial_adder_ctrl.md
Name: digit_serial_adder_ctrl

Overview:
- Sequenced 2-bit-per-cycle adder: one 2-bit ripple slice (two 1-bit full adders) adds two WIDTH-bit operands over WIDTH/2 clock cycles.
- The block holds operand/result shift registers, the inter-digit carry flop, a digit counter and the control FSM, and exposes a start/busy/done handshake.
- Serves as the area-reduced alternative to a full-width ripple adder in the arithmetic datapath.

Parameters:
- WIDTH, 8, operand/result width in bits; must be even and >= 2; elaboration-time error otherwise.
- CNT_W, $clog2(WIDTH/2)+1, digit counter width (derived; not to be overridden).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A; sampled on the accepting edge.
- b  input  WIDTH  operand B; sampled on the accepting edge.
- cin  input  1  carry-in to digit 0; sampled on the accepting edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when the result becomes valid.
- sum  output  WIDTH  result; holds its value from done until the next accept.
- cout  output  1  carry-out of the MSB digit; held like sum.

Behaviour:
- Reset: the async assert of rst_n forces state=IDLE and clears busy, done, sum, cout, the counter, the carry flop and the operand registers to 0. Deassertion is synchronous to clk (the synchronizer sits outside this block).
- FSM states: IDLE, RUN, DONE.
- IDLE with start=1: latch a, b into the shift registers, load the carry flop with cin, set cnt=0, go to RUN. With start=0: stay in IDLE.
- RUN, each cycle:
  - The slice adds A[1:0] + B[1:0] + carry.
  - The 2-bit slice sum shifts into the top of the result register (LSB digit first, so it ends right-aligned).
  - A and B shift right by 2; the carry flop takes the slice carry-out; cnt increments.
  - When cnt reaches WIDTH/2-1: on that edge, write the final digit, register cout from the slice carry-out, go to DONE.
  - start is ignored in RUN; no queueing.
- DONE (exactly one cycle): done=1, busy=0. With start=1: accept a new operation exactly as from IDLE (back-to-back, no bubble). Otherwise go to IDLE.
- Latency: accept edge at cycle T. busy=1 for cycles T+1 .. T+WIDTH/2. done=1 in cycle T+WIDTH/2+1. Throughput is one result per WIDTH/2+1 cycles.
- sum/cout are not updated during RUN; the shadow result register is copied to sum/cout on the final RUN edge. So sum/cout show the previous result until done.
- Arithmetic: unsigned modulo 2^WIDTH; {cout,sum} = a + b + cin exactly.
- Reset mid-RUN: the operation is abandoned, all outputs go to 0, and no done pulse is produced after release.
- Operands changing after the accept edge have no effect.

Optional Feature:
- Macro: DSA_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled on the accept edge.
  - sub=1 latches ~b and forces the carry flop to 1 (cin ignored), so sum = a - b mod 2^WIDTH and cout = 1 means no borrow.
  - sub=0 behaves as the base block.
- Undefined: the sub port is absent and the block is add-only; port list and timing are otherwise identical.

Test Plan:
- Reset then idle: rst_n=0 for 3 cycles, release, start=0 for 10 cycles -> busy=done=sum=cout=0 throughout.
- Basic add, WIDTH=8: a=0x3C, b=0x45, cin=0, start for 1 cycle -> busy for 4 cycles; done pulse on the 5th cycle after accept; sum=0x81, cout=0.
- Carry ripple across all digits: a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1; also a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Start while busy and back-to-back: pulse start twice during RUN -> ignored, only one done. Then hold start=1 in the DONE cycle with a=0x10, b=0x01 -> second done 5 cycles later, sum=0x11, no idle gap.
- Reset mid-operation: accept a=0xAA, b=0x55, assert rst_n=0 in the 2nd RUN cycle -> outputs 0 immediately (async); no done after release. A new op a=0x01, b=0x01 then gives sum=0x02.
- DSA_SUB_EN defined: sub=1, a=0x05, b=0x07 -> sum=0xFE, cout=0. sub=1, a=0x07, b=0x05 -> sum=0x02, cout=1.
